// File: rtl/tinyalu_pkg.sv
// Shared types for the tiny ALU command path: opcodes, sequencer states, command word.
package tinyalu_pkg;

  typedef enum logic [2:0] {
    OP_NO_OP = 3'b000,
    OP_ADD   = 3'b001,
    OP_AND   = 3'b010,
    OP_XOR   = 3'b011,
    OP_MUL   = 3'b100
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  // Codes above MUL have no ALU behaviour and are answered with an error.
  function automatic logic op_is_legal(input logic [2:0] op);
    return op <= 3'(OP_MUL);
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous command FIFO; pop data is the combinational head, flags are registered-pointer derived.
// Wrap bit on each pointer separates full from empty; push ignored when full, pop ignored when empty.
module tinyalu_cmd_fifo
  import tinyalu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t pop_data,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_INC = (AW + 1)'(1);

  cmd_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_INC;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + PTR_INC;
      end
    end
  end

endmodule

// File: rtl/tinyalu_cmd_sequencer.sv
// Buffers ALU commands, issues them one at a time over start/done and returns results on a rsp channel.
// Accept to rsp_valid is 3 cycles plus ALU latency; rsp stalls hold the FSM in RESP and let the FIFO fill.
module tinyalu_cmd_sequencer
  import tinyalu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [2:0]  cmd_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_op,
  output logic        rsp_err
);

  localparam int             CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] tmo_cnt;
  cmd_t             push_data;
  cmd_t             head;
  logic             full;
  logic             empty;
  logic             pop;

  assign push_data = '{a: cmd_a, b: cmd_b, op: cmd_op};
  assign cmd_ready = !full;
  assign pop       = (state == ST_IDLE) && !empty;

  tinyalu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (cmd_valid),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      tmo_cnt    <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_start  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
            state  <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          tmo_cnt <= '0;
          if (alu_op == OP_NO_OP || !op_is_legal(alu_op)) begin
            // Answered locally; the ALU never sees these codes.
            rsp_result <= '0;
            rsp_err    <= (alu_op != OP_NO_OP);
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            alu_start <= 1'b1;
            state     <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (alu_done) begin
            // Done is checked first so a result on the final cycle still counts.
            alu_start  <= 1'b0;
            rsp_result <= alu_result;
            rsp_err    <= 1'b0;
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else if (tmo_cnt == CNT_MAX) begin
            alu_start  <= 1'b0;
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_op     <= alu_op;
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_INC;
          end
        end

        ST_RESP: begin
          // alu_op stays put here: the ALU selects its result path on op[2].
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinyalu_cmd_sequencer.sv
// Directed bench for tinyalu_cmd_sequencer with a small ALU responder and hand-computed results.
module tb_tinyalu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err;

  always #5 clk = ~clk;

  tinyalu_cmd_sequencer #(.FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err)
  );

  // ALU responder: auto mode answers two cycles after start; otherwise the main sequence drives done.
  logic        auto_en;
  logic        auto_done = 1'b0;
  logic [15:0] auto_res = '0;
  int          auto_cnt = 0;
  logic        man_done;
  logic [15:0] man_res;

  assign alu_done   = auto_en ? auto_done : man_done;
  assign alu_result = auto_en ? auto_res  : man_res;

  always @(posedge clk) begin
    auto_done <= 1'b0;
    if (reset) begin
      auto_cnt <= 0;
    end else if (alu_start && !auto_done) begin
      if (auto_cnt == 1) begin
        auto_done <= 1'b1;
        auto_cnt  <= 0;
        case (alu_op)
          3'b001:  auto_res <= {8'h00, alu_a} + {8'h00, alu_b};
          3'b010:  auto_res <= {8'h00, alu_a & alu_b};
          3'b011:  auto_res <= {8'h00, alu_a ^ alu_b};
          3'b100:  auto_res <= alu_a * alu_b;
          default: auto_res <= 16'hDEAD;
        endcase
      end else begin
        auto_cnt <= auto_cnt + 1;
      end
    end else begin
      auto_cnt <= 0;
    end
  end

  // Protocol monitors.
  logic       prev_start = 1'b0;
  logic [7:0] prev_a = '0;
  logic [7:0] prev_b = '0;
  logic [2:0] prev_op = '0;
  int         start_cnt = 0;
  int         rsp_cnt = 0;
  int         hi_run = 0;
  int         last_run = 0;
  int         low_run = 100;
  logic       stab_bad = 1'b0;
  logic       gap_bad = 1'b0;

  always @(posedge clk) begin
    prev_start <= alu_start;
    prev_a     <= alu_a;
    prev_b     <= alu_b;
    prev_op    <= alu_op;
    if (alu_start && prev_start && (alu_a != prev_a || alu_b != prev_b || alu_op != prev_op))
      stab_bad <= 1'b1;
    if (alu_start && !prev_start) begin
      start_cnt <= start_cnt + 1;
      if (low_run < 2) gap_bad <= 1'b1;
    end
    if (alu_start) begin
      hi_run  <= hi_run + 1;
      low_run <= 0;
    end else begin
      if (hi_run != 0) last_run <= hi_run;
      hi_run <= 0;
      if (low_run < 100) low_run <= low_run + 1;
    end
    if (!reset && rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    int n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, output int lat);
    int n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    lat = n;
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
  endtask

  task automatic handshake(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_drop"}, rsp_valid, 0);
  endtask

  logic [7:0] t2_a  [5] = '{8'h01, 8'h03, 8'h05, 8'h07, 8'h09};
  logic [7:0] t2_b  [5] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h0A};
  logic [2:0] t2_op [5] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b001};

  initial begin
    int   lat;
    int   s0;
    int   r0;
    int   n;
    logic hold_ok;

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_a = '0;
    cmd_b = '0;
    cmd_op = '0;
    rsp_ready = 1'b0;
    auto_en = 1'b1;
    man_done = 1'b0;
    man_res = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_alu_bus", {alu_a, alu_b, alu_op}, 0);
    chk("rst_rsp", {rsp_valid, rsp_result, rsp_op, rsp_err}, 0);
    reset = 1'b0;
    @(negedge clk);

    // Add FF+01 through the ALU
    push(8'hFF, 8'h01, 3'b001);
    wait_rsp("add", lat);
    chk("add_latency", lat, 5);
    chk("add_result", rsp_result, 16'h0100);
    chk("add_op", rsp_op, 3'b001);
    chk("add_err", rsp_err, 0);
    chk("add_start_low_in_resp", alu_start, 0);
    chk("add_alu_op_held", alu_op, 3'b001);
    chk("add_alu_a_held", alu_a, 8'hFF);
    handshake("add");
    chk("add_start_run", last_run, 3);
    chk("add_start_count", start_cnt, 1);
    chk("add_rsp_count", rsp_cnt, 1);
    chk("add_operands_stable", stab_bad, 0);

    // Stalled ALU: five commands, FIFO fills, each times out
    auto_en = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(t2_a[i], t2_b[i], t2_op[i]);
    chk("t2_fifo_full", cmd_ready, 0);
    for (int i = 0; i < 5; i++) begin
      wait_rsp("t2", lat);
      chk("t2_result", rsp_result, 16'h0000);
      chk("t2_err", rsp_err, 1);
      chk("t2_op", rsp_op, t2_op[i]);
      @(negedge clk);
      chk("t2_start_run", last_run, 16);
    end
    rsp_ready = 1'b0;
    chk("t2_rsp_count", rsp_cnt, 6);
    chk("t2_cmd_ready_after", cmd_ready, 1);

    // mul then xor with the consumer stalled
    auto_en = 1'b1;
    push(8'hFF, 8'hFF, 3'b100);
    push(8'hAA, 8'h55, 3'b011);
    wait_rsp("mul", lat);
    chk("mul_result", rsp_result, 16'hFE01);
    chk("mul_err", rsp_err, 0);
    s0 = start_cnt;
    hold_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_result == 16'hFE01 && rsp_op == 3'b100 && alu_op == 3'b100))
        hold_ok = 1'b0;
    end
    chk("mul_held_stable", hold_ok, 1);
    chk("xor_not_started", start_cnt, s0);
    handshake("mul");
    wait_rsp("xor", lat);
    chk("xor_result", rsp_result, 16'h00FF);
    chk("xor_op", rsp_op, 3'b011);
    chk("xor_err", rsp_err, 0);
    handshake("xor");

    // no_op and illegal opcode never reach the ALU
    s0 = start_cnt;
    push(8'h12, 8'h34, 3'b000);
    push(8'h56, 8'h78, 3'b110);
    wait_rsp("noop", lat);
    chk("noop_rsp", {rsp_result, rsp_op, rsp_err}, {16'h0000, 3'b000, 1'b0});
    handshake("noop");
    wait_rsp("illegal", lat);
    chk("illegal_rsp", {rsp_result, rsp_op, rsp_err}, {16'h0000, 3'b110, 1'b1});
    handshake("illegal");
    chk("noop_illegal_no_start", start_cnt, s0);

    // Reset during WAIT aborts the mul silently
    auto_en = 1'b0;
    push(8'h03, 8'h04, 3'b100);
    repeat (5) @(negedge clk);
    chk("abort_in_wait", alu_start, 1);
    r0 = rsp_cnt;
    rsp_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs_zero",
        {alu_a, alu_b, alu_op, alu_start, rsp_valid, rsp_result, rsp_op, rsp_err}, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_rsp", rsp_cnt, r0);
    chk("abort_no_restart", alu_start, 0);
    rsp_ready = 1'b0;
    auto_en = 1'b1;
    push(8'h0F, 8'h3C, 3'b010);
    wait_rsp("and", lat);
    chk("and_result", rsp_result, 16'h000C);
    chk("and_op", rsp_op, 3'b010);
    handshake("and");

    // done on the final timeout cycle wins
    auto_en = 1'b0;
    push(8'h10, 8'h20, 3'b001);
    n = 0;
    while (!alu_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("edge_start_seen", alu_start, 1);
    repeat (15) @(negedge clk);
    man_res = 16'h0030;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    chk("edge_rsp_valid", rsp_valid, 1);
    chk("edge_result", rsp_result, 16'h0030);
    chk("edge_err", rsp_err, 0);
    handshake("edge");
    chk("edge_start_run", last_run, 16);

    // Spurious done while idle
    r0 = rsp_cnt;
    s0 = start_cnt;
    rsp_ready = 1'b1;
    man_res = 16'hBEEF;
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (4) @(negedge clk);
    chk("spurious_no_valid", rsp_valid, 0);
    chk("spurious_no_rsp", rsp_cnt, r0);
    chk("spurious_no_start", start_cnt, s0);
    chk("no_back_to_back_start", gap_bad, 0);
    chk("operands_stable_all", stab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
